softmax_output_collector: RTL

Capture block at the output end of the softmax datapath. It accepts the `exp_2_data_valid`/`exp_2_data` result stream produced by the softmax top level, one IEEE-754 single-precision word per valid cycle. It stores one frame of `number_of_data` results in an internal buffer and tracks the running maximum and its index (argmax). It then exposes the frame through a registered random-access read port until software or the sequencer re-arms it.

---
 rtl/softmax_output_collector_if.sv | 30 +++
 rtl/softmax_output_collector.sv | 124 ++++++++++++
 2 files changed

// File: rtl/softmax_output_collector_if.sv
// Bundle of the result stream, control and read-port signals for the softmax output collector.
// The slave side is the collector; the master side is the sequencer/software that feeds and reads it.
interface softmax_output_collector_if #(
  parameter int unsigned data_size      = 32,
  parameter int unsigned number_of_data = 10
);
  localparam int unsigned IW = ($clog2(number_of_data) > 1) ? $clog2(number_of_data) : 1;
  localparam int unsigned CW = $clog2(number_of_data + 1);

  logic                 exp_2_data_valid_i;
  logic [data_size-1:0] exp_2_data_i;
  logic                 clear_i;
  logic [IW-1:0]        rd_addr_i;
  logic [data_size-1:0] rd_data_o;
  logic [CW-1:0]        count_o;
  logic                 done_o;
  logic [data_size-1:0] max_data_o;
  logic [IW-1:0]        max_index_o;
  logic                 overflow_o;

  modport master (
    output exp_2_data_valid_i, exp_2_data_i, clear_i, rd_addr_i,
    input  rd_data_o, count_o, done_o, max_data_o, max_index_o, overflow_o
  );

  modport slave (
    input  exp_2_data_valid_i, exp_2_data_i, clear_i, rd_addr_i,
    output rd_data_o, count_o, done_o, max_data_o, max_index_o, overflow_o
  );
endinterface

// File: rtl/softmax_output_collector.sv
// Captures one frame of softmax results, tracks the argmax and serves the frame through a
// registered read port until re-armed by clear.
module softmax_output_collector #(
  parameter int unsigned data_size      = 32,
  parameter int unsigned number_of_data = 10
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  softmax_output_collector_if.slave     bus
);
  localparam int unsigned IW = ($clog2(number_of_data) > 1) ? $clog2(number_of_data) : 1;
  localparam int unsigned CW = $clog2(number_of_data + 1);

  typedef enum logic [0:0] {StCollect, StDone} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [data_size-1:0] max_data_q, max_data_d;
  logic [IW-1:0]        max_index_q, max_index_d;
  logic [data_size-1:0] rd_data_q, rd_data_d;
  logic                 wr_en;

  logic [data_size-1:0] mem_q [number_of_data];

  // IEEE-754 a > b on raw bits; NaN/denormals deliberately follow the plain bit ordering.
  function automatic logic fp_gt(input logic [data_size-1:0] a, input logic [data_size-1:0] b);
    logic sa, sb;
    sa = a[data_size-1];
    sb = b[data_size-1];
    if (sa != sb) begin
      return sb;
    end else if (!sa) begin
      return a[data_size-2:0] > b[data_size-2:0];
    end else begin
      return a[data_size-2:0] < b[data_size-2:0];
    end
  endfunction

  // Next-state: clear beats a same-cycle valid; beats in StDone only raise overflow.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    max_data_d  = max_data_q;
    max_index_d = max_index_q;
    wr_en       = 1'b0;
    if (bus.clear_i) begin
      state_d     = StCollect;
      count_d     = '0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      max_data_d  = '0;
      max_index_d = '0;
    end else if (bus.exp_2_data_valid_i) begin
      unique case (state_q)
        StCollect: begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          // Strict compare keeps the earliest index on ties.
          if (count_q == '0 || fp_gt(bus.exp_2_data_i, max_data_q)) begin
            max_data_d  = bus.exp_2_data_i;
            max_index_d = count_q[IW-1:0];
          end
          if (count_q == CW'(number_of_data - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          overflow_d = 1'b1;
        end
        default: begin
          state_d = StCollect;
        end
      endcase
    end
  end

  // Read mux: out-of-range addresses return zero; reads see pre-write contents.
  always_comb begin
    rd_data_d = '0;
    if (32'(bus.rd_addr_i) < number_of_data) begin
      rd_data_d = mem_q[bus.rd_addr_i];
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StCollect;
      count_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      max_data_q  <= '0;
      max_index_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      max_data_q  <= max_data_d;
      max_index_q <= max_index_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Frame buffer write; contents are intentionally not reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[count_q[IW-1:0]] <= bus.exp_2_data_i;
    end
  end

  assign bus.rd_data_o   = rd_data_q;
  assign bus.count_o     = count_q;
  assign bus.done_o      = done_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.max_data_o  = max_data_q;
  assign bus.max_index_o = max_index_q;
endmodule
